iob_axi_mem_resp: RTL and testbench
===================================

# iob_axi_mem_resp

AXI4 slave memory responder: the far end of the DMA's AXI master port. It accepts INCR write and read bursts and stores the data in an internal byte-enabled dual-port RAM. It is used as the simulation and FPGA-local backing memory that the DMA engine bursts into and out of. Write and read channels are independent, with at most one burst in flight per direction.

## Interface
- AXI_ADDR_W, 24: AXI address width.
- AXI_DATA_W, 32: data width. Power of 2, at least 8.
- AXI_LEN_W, 8: burst length field width.
- AXI_ID_W, 1: transaction ID width.
- MEM_ADDR_W, 10: RAM word-address width. Depth is 2^MEM_ADDR_W words.
- clk_i  in  1  clock. One clock domain; all logic on its rising edge.
- cke_i  in  1  clock enable. When low, all state holds.
- rst_i  in  1  reset. Synchronous, active-high.
- AW channel: axi_awid_i in ID_W; axi_awaddr_i in ADDR_W; axi_awlen_i in LEN_W; axi_awvalid_i in 1; axi_awready_o out 1.
- W channel: axi_wdata_i in DATA_W; axi_wstrb_i in DATA_W/8; axi_wlast_i in 1; axi_wvalid_i in 1; axi_wready_o out 1.
- B channel: axi_bid_o out ID_W; axi_bresp_o out 2; axi_bvalid_o out 1; axi_bready_i in 1.
- AR channel: axi_arid_i in ID_W; axi_araddr_i in ADDR_W; axi_arlen_i in LEN_W; axi_arvalid_i in 1; axi_arready_o out 1.
- R channel: axi_rid_o out ID_W; axi_rdata_o out DATA_W; axi_rresp_o out 2; axi_rlast_o out 1; axi_rvalid_o out 1; axi_rready_i in 1.
- Size, burst, lock, cache, prot and qos are not ported. Beats are always full-width INCR.

## Operation
- Word index = addr[MEM_ADDR_W+B-1:B], where B = log2(AXI_DATA_W/8). Low address bits are ignored. The index wraps modulo the depth (index 2^MEM_ADDR_W-1 is followed by 0).
- Write FSM:
  - W_IDLE (awready=1). On AW handshake: latch id, word index, len; beat count = 0; go to W_DATA.
  - W_DATA (wready=1). Each W handshake writes wdata to the current index, only the bytes whose wstrb bit is set. Index and beat count then increment.
  - On the beat with wlast=1, go to W_RESP.
  - W_RESP (bvalid=1, bid=latched id). bresp is OKAY (2'b00) if the wlast beat count equals len, otherwise SLVERR (2'b10). On bready, go to W_IDLE.
  - Beats beyond len are still written until wlast arrives.
- Read FSM:
  - R_IDLE (arready=1). On AR handshake: latch id, index, len; beat = 0; go to R_FETCH.
  - R_FETCH: present the index to RAM; go to R_DATA.
  - R_DATA (rvalid=1). rdata is held stable until the handshake. rlast = (beat == len). rresp is always OKAY.
  - On handshake: if rlast, go to R_IDLE; else increment index and beat, go to R_FETCH.
- Same-address read and write in the same cycle: the read returns the old data (read-first).
- rst_i returns both FSMs to IDLE and aborts any in-flight burst. RAM contents are not cleared.
- Reset values: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=rresp=0, bid=rid=0, rdata=0.

## Timing
- AW handshake at cycle N → wready=1 from N+1.
- A write is visible to a read FETCH one cycle after its W handshake.
- wlast handshake at M → bvalid=1 at M+1. awready returns the cycle after the B handshake.
- AR handshake at N → rvalid=1 at N+2.
- R handshake at K on a non-last beat → next rvalid at K+2. Read throughput is one beat per 2 cycles.
- rvalid, rdata, rlast and rid must not change while rvalid=1 and rready=0.
- Outputs are driven from state or registers. There is no combinational path from any *valid_i/*ready_i input to any output.

## Structure
- Shared header iob_axi_mem_resp_conf.vh holds:
  - W_IDLE/W_DATA/W_RESP and R_IDLE/R_FETCH/R_DATA encodings;
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
- Sub-module iob_axi_mem_resp_ram: simple dual-port RAM with:
  - per-byte write enables;
  - registered 1-cycle read;
  - read-first behaviour.

## Test plan
- Write burst: awaddr 0x100, awlen 3, data 0xA0..0xA3, strobes 0xF → bresp 0 at wlast+1. Read awaddr 0x100 awlen 3 → 0xA0..0xA3 returned, rlast on the 4th beat.
- Strobe: 0xFFFFFFFF written to word 0, then wstrb 0x5 with data 0x00000000 → readback 0xFF00FF00.
- Early wlast: awlen 3 with wlast on beat 1 → bresp 2'b10. Only two words are modified.
- Wrap: awaddr at the last word with awlen 1 → the second beat lands in word 0; readback confirms.
- Backpressure: rready low for 5 cycles mid-burst → rdata/rlast held stable, no beat lost. bready held low 3 cycles → bvalid held, awready stays 0.
- Reset mid-burst: rst_i pulsed during W_DATA → next cycle awready=1, wready=0, bvalid=0. Previously written words are intact.

Source files
------------

// File: rtl/iob_axi_mem_resp_pkg.sv
// Shared types and constants for the AXI4 slave memory responder.
package iob_axi_mem_resp_pkg;

    // Write-channel FSM encoding
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    // Read-channel FSM encoding
    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } r_state_t;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/iob_axi_mem_resp_if.sv
// AXI4 bus bundle (AW/W/B/AR/R) between a DMA master and the memory responder.
// Signal suffixes are from the responder's point of view.
interface iob_axi_mem_resp_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int ID_W   = 1
);
    logic [ID_W-1:0]     axi_awid_i;
    logic [ADDR_W-1:0]   axi_awaddr_i;
    logic [LEN_W-1:0]    axi_awlen_i;
    logic                axi_awvalid_i;
    logic                axi_awready_o;

    logic [DATA_W-1:0]   axi_wdata_i;
    logic [DATA_W/8-1:0] axi_wstrb_i;
    logic                axi_wlast_i;
    logic                axi_wvalid_i;
    logic                axi_wready_o;

    logic [ID_W-1:0]     axi_bid_o;
    logic [1:0]          axi_bresp_o;
    logic                axi_bvalid_o;
    logic                axi_bready_i;

    logic [ID_W-1:0]     axi_arid_i;
    logic [ADDR_W-1:0]   axi_araddr_i;
    logic [LEN_W-1:0]    axi_arlen_i;
    logic                axi_arvalid_i;
    logic                axi_arready_o;

    logic [ID_W-1:0]     axi_rid_o;
    logic [DATA_W-1:0]   axi_rdata_o;
    logic [1:0]          axi_rresp_o;
    logic                axi_rlast_o;
    logic                axi_rvalid_o;
    logic                axi_rready_i;

    modport slave (
        input  axi_awid_i, axi_awaddr_i, axi_awlen_i, axi_awvalid_i,
        output axi_awready_o,
        input  axi_wdata_i, axi_wstrb_i, axi_wlast_i, axi_wvalid_i,
        output axi_wready_o,
        output axi_bid_o, axi_bresp_o, axi_bvalid_o,
        input  axi_bready_i,
        input  axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arvalid_i,
        output axi_arready_o,
        output axi_rid_o, axi_rdata_o, axi_rresp_o, axi_rlast_o, axi_rvalid_o,
        input  axi_rready_i
    );

    modport master (
        output axi_awid_i, axi_awaddr_i, axi_awlen_i, axi_awvalid_i,
        input  axi_awready_o,
        output axi_wdata_i, axi_wstrb_i, axi_wlast_i, axi_wvalid_i,
        input  axi_wready_o,
        input  axi_bid_o, axi_bresp_o, axi_bvalid_o,
        output axi_bready_i,
        output axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arvalid_i,
        input  axi_arready_o,
        input  axi_rid_o, axi_rdata_o, axi_rresp_o, axi_rlast_o, axi_rvalid_o,
        output axi_rready_i
    );
endinterface

// File: rtl/iob_axi_mem_resp_ram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port.
// A read and write to the same word in one cycle returns the old word.
module iob_axi_mem_resp_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                rst_i,
    input  logic [DATA_W/8-1:0] we_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic                re_i,
    input  logic [ADDR_W-1:0]   raddr_i,
    output logic [DATA_W-1:0]   rdata_o
);
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Byte-lane writes; contents survive reset
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            for (int i = 0; i < NB; i++) begin
                if (we_i[i]) mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
        end
    end

    // Registered read; NBA ordering gives read-first on address collision
    always_ff @(posedge clk_i) begin
        if (rst_i)                rdata_q <= '0;
        else if (cke_i && re_i)   rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/iob_axi_mem_resp.sv
// AXI4 slave memory responder: independent write and read burst engines,
// one burst in flight per direction, backed by a byte-enabled dual-port RAM.
module iob_axi_mem_resp
    import iob_axi_mem_resp_pkg::*;
#(
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ID_W   = 1,
    parameter int MEM_ADDR_W = 10
) (
    input  logic                 clk_i,
    input  logic                 cke_i,
    input  logic                 rst_i,
    iob_axi_mem_resp_if.slave    axi
);
    localparam int NB = AXI_DATA_W / 8;
    localparam int B  = $clog2(NB);

    // Write channel state
    w_state_t                w_state_q, w_state_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [AXI_ID_W-1:0]     bid_q, bid_d;
    logic [MEM_ADDR_W-1:0]   widx_q, widx_d;
    logic [AXI_LEN_W-1:0]    wlen_q, wlen_d;
    // One extra bit so over-long bursts do not alias back onto len
    logic [AXI_LEN_W:0]      wbeat_q, wbeat_d;
    logic [NB-1:0]           ram_we;

    // Read channel state
    r_state_t                r_state_q, r_state_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic                    rlast_q, rlast_d;
    logic [AXI_ID_W-1:0]     rid_q, rid_d;
    logic [MEM_ADDR_W-1:0]   ridx_q, ridx_d;
    logic [AXI_LEN_W-1:0]    rlen_q, rlen_d;
    logic [AXI_LEN_W-1:0]    rbeat_q, rbeat_d;
    logic                    ram_re;
    logic [AXI_DATA_W-1:0]   ram_rdata;

    // Sub-word address bits and bits above the RAM depth are ignored
    logic unused_addr_bits;
    assign unused_addr_bits = ^{axi.axi_awaddr_i, axi.axi_araddr_i};

    // Write FSM next-state: AW latch, strobed beat writes, B response
    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        bid_d     = bid_q;
        widx_d    = widx_q;
        wlen_d    = wlen_q;
        wbeat_d   = wbeat_q;
        ram_we    = '0;
        case (w_state_q)
            W_IDLE: if (axi.axi_awvalid_i && awready_q) begin
                bid_d     = axi.axi_awid_i;
                widx_d    = axi.axi_awaddr_i[MEM_ADDR_W+B-1:B];
                wlen_d    = axi.axi_awlen_i;
                wbeat_d   = '0;
                awready_d = 1'b0;
                wready_d  = 1'b1;
                w_state_d = W_DATA;
            end
            W_DATA: if (axi.axi_wvalid_i && wready_q) begin
                ram_we  = axi.axi_wstrb_i;
                widx_d  = widx_q + MEM_ADDR_W'(1);
                wbeat_d = wbeat_q + (AXI_LEN_W+1)'(1);
                if (axi.axi_wlast_i) begin
                    bresp_d   = (wbeat_q == {1'b0, wlen_q}) ? RESP_OKAY : RESP_SLVERR;
                    bvalid_d  = 1'b1;
                    wready_d  = 1'b0;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: if (axi.axi_bready_i) begin
                bvalid_d  = 1'b0;
                awready_d = 1'b1;
                w_state_d = W_IDLE;
            end
            default: begin
                awready_d = 1'b1;
                wready_d  = 1'b0;
                bvalid_d  = 1'b0;
                w_state_d = W_IDLE;
            end
        endcase
    end

    // Write FSM registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
            widx_q    <= '0;
            wlen_q    <= '0;
            wbeat_q   <= '0;
        end else if (cke_i) begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
            widx_q    <= widx_d;
            wlen_q    <= wlen_d;
            wbeat_q   <= wbeat_d;
        end
    end

    // Read FSM next-state: one fetch cycle per beat, data held until accepted
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        ridx_d    = ridx_q;
        rlen_d    = rlen_q;
        rbeat_d   = rbeat_q;
        ram_re    = 1'b0;
        case (r_state_q)
            R_IDLE: if (axi.axi_arvalid_i && arready_q) begin
                rid_d     = axi.axi_arid_i;
                ridx_d    = axi.axi_araddr_i[MEM_ADDR_W+B-1:B];
                rlen_d    = axi.axi_arlen_i;
                rbeat_d   = '0;
                arready_d = 1'b0;
                r_state_d = R_FETCH;
            end
            R_FETCH: begin
                ram_re    = 1'b1;
                rvalid_d  = 1'b1;
                rlast_d   = (rbeat_q == rlen_q);
                r_state_d = R_DATA;
            end
            R_DATA: if (axi.axi_rready_i) begin
                rvalid_d = 1'b0;
                rlast_d  = 1'b0;
                if (rlast_q) begin
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end else begin
                    ridx_d    = ridx_q + MEM_ADDR_W'(1);
                    rbeat_d   = rbeat_q + AXI_LEN_W'(1);
                    r_state_d = R_FETCH;
                end
            end
            default: begin
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
                r_state_d = R_IDLE;
            end
        endcase
    end

    // Read FSM registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            ridx_q    <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
        end else if (cke_i) begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            ridx_q    <= ridx_d;
            rlen_q    <= rlen_d;
            rbeat_q   <= rbeat_d;
        end
    end

    iob_axi_mem_resp_ram #(
        .DATA_W (AXI_DATA_W),
        .ADDR_W (MEM_ADDR_W)
    ) u_ram (
        .clk_i   (clk_i),
        .cke_i   (cke_i),
        .rst_i   (rst_i),
        .we_i    (ram_we),
        .waddr_i (widx_q),
        .wdata_i (axi.axi_wdata_i),
        .re_i    (ram_re),
        .raddr_i (ridx_q),
        .rdata_o (ram_rdata)
    );

    assign axi.axi_awready_o = awready_q;
    assign axi.axi_wready_o  = wready_q;
    assign axi.axi_bvalid_o  = bvalid_q;
    assign axi.axi_bresp_o   = bresp_q;
    assign axi.axi_bid_o     = bid_q;
    assign axi.axi_arready_o = arready_q;
    assign axi.axi_rvalid_o  = rvalid_q;
    assign axi.axi_rlast_o   = rlast_q;
    assign axi.axi_rid_o     = rid_q;
    assign axi.axi_rresp_o   = RESP_OKAY;
    assign axi.axi_rdata_o   = ram_rdata;
endmodule

// File: tb/tb_iob_axi_mem_resp.sv
// Bench for iob_axi_mem_resp: reference memory model plus a read-data scoreboard.
module tb_iob_axi_mem_resp;
    localparam int AW = 24, DW = 32, LW = 8, IW = 1, MW = 10;
    localparam int DEPTH = 1 << MW;

    logic clk = 1'b0;
    logic cke, rst;
    always #5 clk = ~clk;

    iob_axi_mem_resp_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ID_W(IW)) bus();

    iob_axi_mem_resp #(
        .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_LEN_W(LW), .AXI_ID_W(IW), .MEM_ADDR_W(MW)
    ) dut (
        .clk_i (clk),
        .cke_i (cke),
        .rst_i (rst),
        .axi   (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        id;
    } rexp_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mdl [DEPTH];
    rexp_t       sb [$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_burst(input logic [23:0] addr, input int len, input int nbeats,
                            input logic [31:0] base, input logic [3:0] strb,
                            input logic id, input int bstall);
        int          idx = int'(addr[11:2]);
        int          n;
        logic [31:0] d;
        logic [1:0]  exp_resp = (nbeats == len + 1) ? 2'b00 : 2'b10;
        bus.axi_awid_i    = id;
        bus.axi_awaddr_i  = addr;
        bus.axi_awlen_i   = len[7:0];
        bus.axi_awvalid_i = 1'b1;
        n = 0;
        while (!bus.axi_awready_o && n < 20) begin tick(); n++; end
        chk("awready", 32'(bus.axi_awready_o), 1);
        tick();
        bus.axi_awvalid_i = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            chk("wready", 32'(bus.axi_wready_o), 1);
            d = base + 32'(i);
            bus.axi_wdata_i  = d;
            bus.axi_wstrb_i  = strb;
            bus.axi_wlast_i  = (i == nbeats - 1);
            bus.axi_wvalid_i = 1'b1;
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[(idx + i) % DEPTH][b*8 +: 8] = d[b*8 +: 8];
            tick();
        end
        bus.axi_wvalid_i = 1'b0;
        bus.axi_wlast_i  = 1'b0;
        chk("bvalid_at_wlast+1", 32'(bus.axi_bvalid_o), 1);
        chk("wready_off", 32'(bus.axi_wready_o), 0);
        chk("bresp", 32'(bus.axi_bresp_o), 32'(exp_resp));
        chk("bid", 32'(bus.axi_bid_o), 32'(id));
        for (int s = 0; s < bstall; s++) begin
            tick();
            chk("bvalid_hold", 32'(bus.axi_bvalid_o), 1);
            chk("awready_busy", 32'(bus.axi_awready_o), 0);
        end
        bus.axi_bready_i = 1'b1;
        tick();
        bus.axi_bready_i = 1'b0;
        chk("bvalid_clr", 32'(bus.axi_bvalid_o), 0);
        chk("awready_back", 32'(bus.axi_awready_o), 1);
    endtask

    task automatic rd_burst(input logic [23:0] addr, input int len, input logic id,
                            input int stall_beat, input int stall_cyc);
        int    idx = int'(addr[11:2]);
        int    n;
        rexp_t e;
        for (int i = 0; i <= len; i++) sb.push_back('{mdl[(idx + i) % DEPTH], i == len, id});
        bus.axi_arid_i    = id;
        bus.axi_araddr_i  = addr;
        bus.axi_arlen_i   = len[7:0];
        bus.axi_arvalid_i = 1'b1;
        n = 0;
        while (!bus.axi_arready_o && n < 20) begin tick(); n++; end
        chk("arready", 32'(bus.axi_arready_o), 1);
        tick();
        bus.axi_arvalid_i = 1'b0;
        for (int i = 0; i <= len; i++) begin
            n = 0;
            while (!bus.axi_rvalid_o && n < 20) begin tick(); n++; end
            chk("rvalid", 32'(bus.axi_rvalid_o), 1);
            chk("r_latency", n, 1);
            if (sb.size() == 0) begin
                chk("sb_nonempty", 0, 1);
            end else begin
                e = sb.pop_front();
                chk("rdata", bus.axi_rdata_o, e.data);
                chk("rlast", 32'(bus.axi_rlast_o), 32'(e.last));
                chk("rid", 32'(bus.axi_rid_o), 32'(e.id));
                chk("rresp", 32'(bus.axi_rresp_o), 0);
                if (i == stall_beat) begin
                    for (int s = 0; s < stall_cyc; s++) begin
                        tick();
                        chk("rvalid_hold", 32'(bus.axi_rvalid_o), 1);
                        chk("rdata_hold", bus.axi_rdata_o, e.data);
                        chk("rlast_hold", 32'(bus.axi_rlast_o), 32'(e.last));
                    end
                end
            end
            bus.axi_rready_i = 1'b1;
            tick();
            bus.axi_rready_i = 1'b0;
        end
        chk("arready_after_last", 32'(bus.axi_arready_o), 1);
    endtask

    initial begin
        int n;
        cke = 1'b1;
        rst = 1'b1;
        bus.axi_awid_i = '0; bus.axi_awaddr_i = '0; bus.axi_awlen_i = '0; bus.axi_awvalid_i = 1'b0;
        bus.axi_wdata_i = '0; bus.axi_wstrb_i = '0; bus.axi_wlast_i = 1'b0; bus.axi_wvalid_i = 1'b0;
        bus.axi_bready_i = 1'b0;
        bus.axi_arid_i = '0; bus.axi_araddr_i = '0; bus.axi_arlen_i = '0; bus.axi_arvalid_i = 1'b0;
        bus.axi_rready_i = 1'b0;
        tick();
        tick();

        // Reset values
        chk("rst_awready", 32'(bus.axi_awready_o), 1);
        chk("rst_arready", 32'(bus.axi_arready_o), 1);
        chk("rst_wready", 32'(bus.axi_wready_o), 0);
        chk("rst_bvalid", 32'(bus.axi_bvalid_o), 0);
        chk("rst_rvalid", 32'(bus.axi_rvalid_o), 0);
        chk("rst_rlast", 32'(bus.axi_rlast_o), 0);
        chk("rst_bresp", 32'(bus.axi_bresp_o), 0);
        chk("rst_rresp", 32'(bus.axi_rresp_o), 0);
        chk("rst_bid", 32'(bus.axi_bid_o), 0);
        chk("rst_rid", 32'(bus.axi_rid_o), 0);
        chk("rst_rdata", bus.axi_rdata_o, 0);
        rst = 1'b0;
        tick();

        // Basic 4-beat burst and readback
        wr_burst(24'h000100, 3, 4, 32'h000000A0, 4'hF, 1'b1, 0);
        rd_burst(24'h000100, 3, 1'b1, -1, 0);

        // Byte strobes: expect FF00FF00
        wr_burst(24'h000000, 0, 1, 32'hFFFFFFFF, 4'hF, 1'b0, 0);
        wr_burst(24'h000000, 0, 1, 32'h00000000, 4'h5, 1'b0, 0);
        rd_burst(24'h000000, 0, 1'b0, -1, 0);

        // Early wlast: SLVERR, only two words change
        wr_burst(24'h000200, 3, 4, 32'h11110000, 4'hF, 1'b0, 0);
        wr_burst(24'h000200, 3, 2, 32'h22220000, 4'hF, 1'b1, 0);
        rd_burst(24'h000200, 3, 1'b0, -1, 0);

        // Index wrap from last word to word 0
        wr_burst(24'h000FFC, 1, 2, 32'hC0DE0000, 4'hF, 1'b1, 0);
        rd_burst(24'h000FFC, 1, 1'b1, -1, 0);
        rd_burst(24'h000000, 0, 1'b0, -1, 0);

        // Backpressure on R and B
        rd_burst(24'h000100, 3, 1'b0, 1, 5);
        wr_burst(24'h000300, 1, 2, 32'h33330000, 4'hF, 1'b0, 3);
        rd_burst(24'h000300, 1, 1'b1, -1, 0);

        // Reset mid-burst: one beat lands, then the burst is aborted
        bus.axi_awid_i    = 1'b1;
        bus.axi_awaddr_i  = 24'h000100;
        bus.axi_awlen_i   = 8'd3;
        bus.axi_awvalid_i = 1'b1;
        n = 0;
        while (!bus.axi_awready_o && n < 20) begin tick(); n++; end
        chk("mid_awready", 32'(bus.axi_awready_o), 1);
        tick();
        bus.axi_awvalid_i = 1'b0;
        bus.axi_wdata_i   = 32'hDEAD0000;
        bus.axi_wstrb_i   = 4'hF;
        bus.axi_wlast_i   = 1'b0;
        bus.axi_wvalid_i  = 1'b1;
        mdl[12'h040]      = 32'hDEAD0000;
        tick();
        bus.axi_wvalid_i  = 1'b0;
        chk("mid_wready", 32'(bus.axi_wready_o), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("post_rst_awready", 32'(bus.axi_awready_o), 1);
        chk("post_rst_wready", 32'(bus.axi_wready_o), 0);
        chk("post_rst_bvalid", 32'(bus.axi_bvalid_o), 0);
        rd_burst(24'h000100, 3, 1'b0, -1, 0);
        rd_burst(24'h000200, 3, 1'b1, -1, 0);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
